// File: rtl/fnd_pkg.sv
// Shared constants for the FND scan controller: glyphs, FSM encoding, segment bits.
package fnd_pkg;

  // Active-low glyphs, bit order {dp,g,f,e,d,c,b,a}; dp bit is 1 (off) in every glyph.
  localparam logic [7:0] GLYPH_0   = 8'hC0;
  localparam logic [7:0] GLYPH_1   = 8'hF9;
  localparam logic [7:0] GLYPH_2   = 8'hA4;
  localparam logic [7:0] GLYPH_3   = 8'hB0;
  localparam logic [7:0] GLYPH_4   = 8'h99;
  localparam logic [7:0] GLYPH_5   = 8'h92;
  localparam logic [7:0] GLYPH_6   = 8'h82;
  localparam logic [7:0] GLYPH_7   = 8'hF8;
  localparam logic [7:0] GLYPH_8   = 8'h80;
  localparam logic [7:0] GLYPH_9   = 8'h90;
  localparam logic [7:0] GLYPH_A   = 8'h88;
  localparam logic [7:0] GLYPH_B   = 8'h83;
  localparam logic [7:0] GLYPH_C   = 8'hC6;
  localparam logic [7:0] GLYPH_D   = 8'hA1;
  localparam logic [7:0] GLYPH_E   = 8'h86;
  localparam logic [7:0] GLYPH_F   = 8'h8E;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Segment bit index of the decimal point.
  localparam int unsigned SEG_DP = 7;

  // Scan FSM encoding.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DEAD = 2'd1;
  localparam logic [1:0] ST_SHOW = 2'd2;

endpackage

// File: rtl/fnd_seg_decoder.sv
// Combinational 4-bit code + decimal point to active-low 7-segment pattern.
module fnd_seg_decoder
  import fnd_pkg::*;
(
  input  logic [3:0] code_i,
  input  logic       dp_i,
  output logic [7:0] seg_c_o
);

  // Glyph lookup, then pull the dp bit low when requested.
  always_comb begin
    seg_c_o = SEG_BLANK;
    case (code_i)
      4'h0: seg_c_o = GLYPH_0;
      4'h1: seg_c_o = GLYPH_1;
      4'h2: seg_c_o = GLYPH_2;
      4'h3: seg_c_o = GLYPH_3;
      4'h4: seg_c_o = GLYPH_4;
      4'h5: seg_c_o = GLYPH_5;
      4'h6: seg_c_o = GLYPH_6;
      4'h7: seg_c_o = GLYPH_7;
      4'h8: seg_c_o = GLYPH_8;
      4'h9: seg_c_o = GLYPH_9;
      4'hA: seg_c_o = GLYPH_A;
      4'hB: seg_c_o = GLYPH_B;
      4'hC: seg_c_o = GLYPH_C;
      4'hD: seg_c_o = GLYPH_D;
      4'hE: seg_c_o = GLYPH_E;
      default: seg_c_o = GLYPH_F;
    endcase
    if (dp_i) seg_c_o[SEG_DP] = 1'b0;
  end

endmodule

// File: rtl/fnd_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with double-buffered digits,
// per-slot blanking dead-time and leading-zero suppression.
module fnd_scan_ctrl
  import fnd_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SCAN_DIV   = 100000,
  parameter int unsigned DEAD_CYC   = 1000
) (
  input  logic                    iCLK,
  input  logic                    iRSTn,
  input  logic                    iEN,
  input  logic                    iLOAD,
  input  logic [4*NUM_DIGITS-1:0] iDIGITS,
  input  logic [NUM_DIGITS-1:0]   iDP,
  input  logic                    iBLANK_LZ,
  output logic [7:0]              oSEG,
  output logic [NUM_DIGITS-1:0]   oCOM,
  output logic                    oFRAME
);

  localparam int unsigned CW = $clog2(SCAN_DIV);
  localparam int unsigned IW = $clog2(NUM_DIGITS);
  localparam int unsigned DW = 4 * NUM_DIGITS;
  localparam int unsigned SW = IW + 2;

  logic [1:0]            state_q, state_d;
  logic [CW-1:0]         slot_q, slot_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DW-1:0]         pend_dig_q, pend_dig_d, act_dig_q, act_dig_d;
  logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
  logic                  pend_q, pend_d;
  logic [7:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] com_q, com_d;
  logic                  frame_q, frame_d;

  logic          slot_end_c, last_c, wrap_c, blank_c, cur_dp_c;
  logic [SW-1:0] shamt_c;
  logic [3:0]    cur_code_c;
  logic [7:0]    dec_seg_c;

  // Current-digit selection and wrap/blank qualifiers.
  always_comb begin
    slot_end_c = (state_q == ST_SHOW) && (slot_q == CW'(SCAN_DIV - 1));
    last_c     = (idx_q == IW'(NUM_DIGITS - 1));
    wrap_c     = iEN && slot_end_c && last_c;
    shamt_c    = {idx_q, 2'b00};
    cur_code_c = 4'(act_dig_q >> shamt_c);
    cur_dp_c   = act_dp_q[idx_q];
    // Digit is a leading zero when it and every higher digit are zero.
    blank_c    = iBLANK_LZ && (idx_q != '0) && ((act_dig_q >> shamt_c) == '0);
  end

  fnd_seg_decoder u_dec (
    .code_i  (cur_code_c),
    .dp_i    (cur_dp_c),
    .seg_c_o (dec_seg_c)
  );

  // Scan FSM next state with slot counter and digit index.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    idx_d   = idx_q;
    if (!iEN) begin
      state_d = ST_IDLE;
      slot_d  = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_DEAD;
          slot_d  = '0;
          idx_d   = '0;
        end
        ST_DEAD: begin
          slot_d = slot_q + CW'(1);
          if (slot_q == CW'(DEAD_CYC - 1)) state_d = ST_SHOW;
        end
        ST_SHOW: begin
          if (slot_end_c) begin
            slot_d  = '0;
            idx_d   = last_c ? '0 : idx_q + IW'(1);
            state_d = ST_DEAD;
          end else begin
            slot_d = slot_q + CW'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          slot_d  = '0;
          idx_d   = '0;
        end
      endcase
    end
  end

  // Double buffer: pending captures loads, active swaps only at frame wrap or while idle.
  always_comb begin
    pend_dig_d = pend_dig_q;
    pend_dp_d  = pend_dp_q;
    pend_d     = pend_q;
    act_dig_d  = act_dig_q;
    act_dp_d   = act_dp_q;
    if (iLOAD) begin
      pend_dig_d = iDIGITS;
      pend_dp_d  = iDP;
    end
    if ((state_q == ST_IDLE) || wrap_c) begin
      if (iLOAD) begin
        act_dig_d = iDIGITS;
        act_dp_d  = iDP;
        pend_d    = 1'b0;
      end else if (pend_q) begin
        act_dig_d = pend_dig_q;
        act_dp_d  = pend_dp_q;
        pend_d    = 1'b0;
      end
    end else if (iLOAD) begin
      pend_d = 1'b1;
    end
  end

  // Pin values for the next cycle; dark unless showing an unblanked digit.
  always_comb begin
    seg_d   = SEG_BLANK;
    com_d   = '1;
    frame_d = wrap_c;
    if (iEN && (state_q == ST_SHOW) && !blank_c) begin
      seg_d = dec_seg_c;
      com_d = ~(NUM_DIGITS'(1) << idx_q);
    end
  end

  // State, buffer and output registers.
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      state_q    <= ST_IDLE;
      slot_q     <= '0;
      idx_q      <= '0;
      pend_dig_q <= '0;
      pend_dp_q  <= '0;
      pend_q     <= 1'b0;
      act_dig_q  <= '0;
      act_dp_q   <= '0;
      seg_q      <= SEG_BLANK;
      com_q      <= '1;
      frame_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      idx_q      <= idx_d;
      pend_dig_q <= pend_dig_d;
      pend_dp_q  <= pend_dp_d;
      pend_q     <= pend_d;
      act_dig_q  <= act_dig_d;
      act_dp_q   <= act_dp_d;
      seg_q      <= seg_d;
      com_q      <= com_d;
      frame_q    <= frame_d;
    end
  end

  assign oSEG   = seg_q;
  assign oCOM   = com_q;
  assign oFRAME = frame_q;

endmodule
